lt_compare_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one `comparator_lt` and one `comparator_eq` instance among `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake, registers the operands, evaluates the compare, and returns a tagged result on a single response channel. It sits between the ALU/branch-side requesters and the shared compare datapath, so the structural comparator is instantiated once per cluster instead of once per requester.

---
 rtl/lt_compare_arbiter.sv | 171 +++++++++++++++++
 tb/tb_lt_compare_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lt_compare_arbiter.sv
// rtl/lt_compare_arbiter.sv - round-robin sequencer sharing one lt/eq comparator pair; option LT_ARBITER_UNSIGNED_EN

// Structural signed less-than comparator.
module comparator_lt #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt
);
   assign lt = $signed(a) < $signed(b);
endmodule

// Structural equality comparator.
module comparator_eq #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         eq
);
   assign eq = (a == b);
endmodule

module lt_compare_arbiter #(
   parameter int N    = 32,
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
`ifdef LT_ARBITER_UNSIGNED_EN
   input  logic [NREQ-1:0]   req_unsigned,
`endif
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_lt,
   output logic              rsp_eq
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COMPARE = 2'b01,
      RESPOND = 2'b10
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] ptr_next;
   logic           grant_found;
   logic           accept;
   logic [IDW:0]   idx_sum;
   logic [IDW:0]   wrap_sum;
   logic [N-1:0]   op_a;
   logic [N-1:0]   op_b;
   logic [IDW-1:0] id_q;
   logic [N-1:0]   cmp_a;
   logic [N-1:0]   cmp_b;
   logic           cmp_lt;
   logic           cmp_eq;

`ifdef LT_ARBITER_UNSIGNED_EN
   logic uns_q;
   // Flipping both MSBs turns the signed compare into an unsigned one; equality is unchanged.
   assign cmp_a = {op_a[N-1] ^ uns_q, op_a[N-2:0]};
   assign cmp_b = {op_b[N-1] ^ uns_q, op_b[N-2:0]};
`else
   assign cmp_a = op_a;
   assign cmp_b = op_b;
`endif

   comparator_lt #(.N(N)) u_lt (.a(cmp_a), .b(cmp_b), .lt(cmp_lt));
   comparator_eq #(.N(N)) u_eq (.a(cmp_a), .b(cmp_b), .eq(cmp_eq));

   // Round-robin search: first valid requester at or above ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      winner      = '0;
      idx_sum     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_sum = {1'b0, ptr} + (IDW+1)'(k);
         if (idx_sum >= (IDW+1)'(NREQ)) begin
            idx_sum = idx_sum - (IDW+1)'(NREQ);
         end
         if (!grant_found && req_valid[idx_sum[IDW-1:0]]) begin
            grant_found = 1'b1;
            winner      = idx_sum[IDW-1:0];
         end
      end
      wrap_sum = {1'b0, winner} + (IDW+1)'(1);
      if (wrap_sum >= (IDW+1)'(NREQ)) begin
         wrap_sum = '0;
      end
      ptr_next = wrap_sum[IDW-1:0];
   end

   // Next-state and grant decode; ready is only offered from IDLE outside reset.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rst && grant_found) begin
               req_ready[winner] = 1'b1;
               accept            = 1'b1;
               state_d           = COMPARE;
            end
         end
         COMPARE: state_d = RESPOND;
         RESPOND: begin
            if (rsp_valid && rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture, pointer advance and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         id_q      <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_lt    <= 1'b0;
         rsp_eq    <= 1'b0;
`ifdef LT_ARBITER_UNSIGNED_EN
         uns_q     <= 1'b0;
`endif
      end else begin
         if (accept) begin
            op_a  <= req_a[int'(winner)*N +: N];
            op_b  <= req_b[int'(winner)*N +: N];
            id_q  <= winner;
            ptr   <= ptr_next;
`ifdef LT_ARBITER_UNSIGNED_EN
            uns_q <= req_unsigned[winner];
`endif
         end
         if (state_q == COMPARE) begin
            rsp_lt    <= cmp_lt;
            rsp_eq    <= cmp_eq;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
         end else if (state_q == RESPOND && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lt_compare_arbiter.sv
// tb/tb_lt_compare_arbiter.sv - scoreboard bench for lt_compare_arbiter; option LT_ARBITER_UNSIGNED_EN

module tb_lt_compare_arbiter;

   localparam int N    = 32;
   localparam int NREQ = 4;
`ifdef LT_ARBITER_UNSIGNED_EN
   localparam int N_DELIVER = 10;
`else
   localparam int N_DELIVER = 9;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
`ifdef LT_ARBITER_UNSIGNED_EN
   logic [NREQ-1:0]   req_unsigned;
`endif
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic              rsp_lt;
   logic              rsp_eq;

   typedef struct packed {
      logic [1:0] id;
      logic       lt;
      logic       eq;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   delivered = 0;
   int   cyc = 0;

   lt_compare_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a(req_a),
      .req_b(req_b),
`ifdef LT_ARBITER_UNSIGNED_EN
      .req_unsigned(req_unsigned),
`endif
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id(rsp_id),
      .rsp_lt(rsp_lt),
      .rsp_eq(rsp_eq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [1:0] id, input logic lt, input logic eq);
      exp_t e;
      e.id = id;
      e.lt = lt;
      e.eq = eq;
      sbq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int budget, output logic [NREQ-1:0] g);
      g = '0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (|req_ready) begin
            g = req_ready;
            break;
         end
      end
   endtask

   // Monitor: pops the scoreboard on every completed response handshake.
   always @(negedge clk) begin
      exp_t e;
      check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (!rst && rsp_valid && rsp_ready) begin
         if (sbq.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_lt", 32'(rsp_lt), 32'(e.lt));
            check("rsp_eq", 32'(rsp_eq), 32'(e.eq));
            delivered++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [NREQ-1:0] g;
      logic [31:0] va [NREQ];
      logic [31:0] vb [NREQ];
      logic        el [NREQ];
      logic        ee [NREQ];
      int          t0;
      int          last;

      va[0] = 32'd10;          vb[0] = 32'd20;          el[0] = 1'b1; ee[0] = 1'b0;
      va[1] = 32'd7;           vb[1] = 32'd7;           el[1] = 1'b0; ee[1] = 1'b1;
      va[2] = 32'hFFFF_FFFB;   vb[2] = 32'd3;           el[2] = 1'b1; ee[2] = 1'b0;
      va[3] = 32'h8000_0000;   vb[3] = 32'h8000_0000;   el[3] = 1'b0; ee[3] = 1'b1;

      rst       = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
`ifdef LT_ARBITER_UNSIGNED_EN
      req_unsigned = '0;
`endif
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*N +: N] = va[i];
         req_b[i*N +: N] = vb[i];
      end

      // Reset with every requester asking.
      @(negedge clk);
      check("reset_req_ready_0", 32'(req_ready), 32'd0);
      tick();
      @(negedge clk);
      check("reset_req_ready_1", 32'(req_ready), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_id", 32'(rsp_id), 32'd0);
      check("reset_rsp_lt", 32'(rsp_lt), 32'd0);
      check("reset_rsp_eq", 32'(rsp_eq), 32'd0);
      tick();
      rst = 1'b0;

      // Round-robin with all four held valid.
      last = 0;
      for (int gi = 0; gi < 5; gi++) begin
         wait_grant(8, g);
         check("rr_grant", 32'(g), 32'(4'b0001 << (gi % 4)));
         if (gi > 0) check("rr_spacing", 32'(cyc - last), 32'd3);
         last = cyc;
         push(2'(gi % 4), el[gi % 4], ee[gi % 4]);
      end
      tick();
      req_valid = '0;
      repeat (6) @(negedge clk);
      check("rr_drained", 32'(sbq.size()), 32'd0);

      // Single signed compare from requester 2, then equality back-to-back.
      tick();
      req_valid = 4'b0100;
      wait_grant(8, g);
      check("single_grant", 32'(g), 32'b0100);
      t0 = cyc;
      push(2'd2, 1'b1, 1'b0);
      tick();
      req_a[2*N +: N] = 32'h8000_0000;
      req_b[2*N +: N] = 32'h8000_0000;
      @(negedge clk);
      check("single_t1_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("single_t2_valid", 32'(rsp_valid), 32'd1);
      wait_grant(8, g);
      check("eq_grant", 32'(g), 32'b0100);
      check("eq_grant_at_t3", 32'(cyc - t0), 32'd3);
      push(2'd2, 1'b0, 1'b1);
      tick();
      req_valid = '0;
      repeat (4) @(negedge clk);

      // Backpressure: requester 3 wins (ptr=3), requester 1 must wait.
      tick();
      rsp_ready = 1'b0;
      req_valid = 4'b1010;
      req_a[3*N +: N] = 32'd100;
      req_b[3*N +: N] = 32'hFFFF_FFFF;
      wait_grant(8, g);
      check("bp_grant", 32'(g), 32'b1000);
      t0 = cyc;
      push(2'd3, 1'b0, 1'b0);
      tick();
      req_valid = 4'b0010;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_id", 32'(rsp_id), 32'd3);
         check("bp_hold_lt", 32'(rsp_lt), 32'd0);
         check("bp_hold_eq", 32'(rsp_eq), 32'd0);
         check("bp_no_ready", 32'(req_ready), 32'd0);
      end
      tick();
      rsp_ready = 1'b1;
      wait_grant(8, g);
      check("bp_next_grant", 32'(g), 32'b0010);
      check("bp_next_at_t8", 32'(cyc - t0), 32'd8);
      push(2'd1, 1'b0, 1'b1);

      // Reset while requester 1's result waits in RESPOND.
      tick();
      rsp_ready = 1'b0;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_valid", 32'(rsp_valid), 32'd1);
      check("rst_pre_id", 32'(rsp_id), 32'd1);
      tick();
      rst = 1'b1;
      req_valid = '1;
      @(negedge clk);
      check("rst_mid_req_ready", 32'(req_ready), 32'd0);
      sbq.delete();
      tick();
      rst = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rst_post_valid", 32'(rsp_valid), 32'd0);
      check("rst_post_id", 32'(rsp_id), 32'd0);
      repeat (5) @(negedge clk);

      // All-ones against one: unsigned (if built) then signed.
      tick();
      req_valid = 4'b0001;
      req_a[0 +: N] = 32'hFFFF_FFFF;
      req_b[0 +: N] = 32'd1;
`ifdef LT_ARBITER_UNSIGNED_EN
      req_unsigned = 4'b0001;
      wait_grant(8, g);
      check("uns_grant", 32'(g), 32'b0001);
      push(2'd0, 1'b0, 1'b0);
      tick();
      req_unsigned = 4'b0000;
`endif
      wait_grant(8, g);
      check("signed_ff_grant", 32'(g), 32'b0001);
      push(2'd0, 1'b1, 1'b0);
      tick();
      req_valid = '0;
      repeat (6) @(negedge clk);

      check("final_drained", 32'(sbq.size()), 32'd0);
      check("final_delivered", 32'(delivered), 32'(N_DELIVER));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
